// File: rtl/alarm_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alarm_mode_ctrl: SET/CLOCK/RING/SNOOZE mode controller for a multi-alarm   |
// | clock. Optional SET inactivity timeout under `SET_TIMEOUT_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alarm_mode_ctrl #(
  parameter int NUM_ALARMS   = 2,
  parameter int SNOOZE_SECS  = 300,
  parameter int SNOOZE_LIMIT = 3,
  parameter int RING_SECS    = 60,
  parameter int IDLE_SECS    = 30,
  localparam int c_FIELDS    = 2 + 2 * NUM_ALARMS,
  localparam int c_IDW       = ($clog2(NUM_ALARMS) < 1) ? 1 : $clog2(NUM_ALARMS),
  localparam int c_SCW       = $clog2(SNOOZE_LIMIT + 1) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic                  up,
  input  logic                  down,
  input  logic                  left,
  input  logic                  right,
  input  logic                  center,
  input  logic [5:0]            secs,
  input  logic [NUM_ALARMS-1:0] alarm_match,
  input  logic [NUM_ALARMS-1:0] alarm_armed,
  output logic                  adjust,
  output logic [c_FIELDS-1:0]   field_en,
  output logic                  ringing,
  output logic [c_IDW-1:0]      ring_id,
  output logic                  snoozing,
  output logic [c_SCW-1:0]      snooze_cnt
);

  localparam int c_FW   = $clog2(c_FIELDS);
  localparam int c_TMAX = (SNOOZE_SECS > RING_SECS) ?
                          ((SNOOZE_SECS > IDLE_SECS) ? SNOOZE_SECS : IDLE_SECS) :
                          ((RING_SECS > IDLE_SECS) ? RING_SECS : IDLE_SECS);
  localparam int c_TW   = $clog2(c_TMAX + 1);

  typedef enum logic [2:0] {
    S_SET    = 3'd0,
    S_CLOCK  = 3'd1,
    S_RING   = 3'd2,
    S_SNOOZE = 3'd3
  } state_t;

  state_t            r_state;
  logic [c_FW-1:0]   r_field;
  logic [c_IDW-1:0]  r_ring_id;
  logic [c_SCW-1:0]  r_snooze_cnt;
  logic [c_TW-1:0]   r_timer;
  logic              r_fired;

  logic w_nav;
  logic w_fire;
  logic w_ring_expire;
  logic w_snooze_expire;

  function automatic logic [c_IDW-1:0] f_lowest(input logic [NUM_ALARMS-1:0] v);
    f_lowest = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--)
      if (v[k]) f_lowest = c_IDW'(k);
  endfunction

  assign w_nav           = up | down | left | right;
  // r_fired blocks a second ring within the same secs==0 window
  assign w_fire          = (secs == 6'd0) && (|(alarm_match & alarm_armed)) && !r_fired;
  assign w_ring_expire   = tick_1hz && (r_timer == c_TW'(RING_SECS - 1));
  assign w_snooze_expire = tick_1hz && (r_timer == c_TW'(SNOOZE_SECS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_SET;
      r_field      <= '0;
      r_ring_id    <= '0;
      r_snooze_cnt <= '0;
      r_timer      <= '0;
      r_fired      <= 1'b0;
    end else begin
      if (secs != 6'd0) r_fired <= 1'b0;
      case (r_state)
        S_SET: begin
          if (right) begin
            r_field <= (r_field == c_FW'(c_FIELDS - 1)) ? '0 : r_field + c_FW'(1);
            r_timer <= '0;
          end else if (left) begin
            r_field <= (r_field == '0) ? c_FW'(c_FIELDS - 1) : r_field - c_FW'(1);
            r_timer <= '0;
          end else if (center) begin
            r_state <= S_CLOCK;
            r_timer <= '0;
          end
`ifdef SET_TIMEOUT_EN
          else if (up || down) begin
            r_timer <= '0;
          end else if (tick_1hz) begin
            if (r_timer == c_TW'(IDLE_SECS - 1)) begin
              r_state <= S_CLOCK;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + c_TW'(1);
            end
          end
`endif
        end
        S_CLOCK: begin
          if (w_fire) begin
            r_state      <= S_RING;
            r_ring_id    <= f_lowest(alarm_match & alarm_armed);
            r_snooze_cnt <= '0;
            r_timer      <= '0;
            r_fired      <= 1'b1;
          end else if (center) begin
            r_state <= S_SET;
            r_field <= '0;
            r_timer <= '0;
          end
        end
        S_RING: begin
          if (w_nav) begin
            r_state <= S_CLOCK;
            r_timer <= '0;
          end else if (center || w_ring_expire) begin
            r_timer <= '0;
            if (r_snooze_cnt < c_SCW'(SNOOZE_LIMIT)) begin
              r_state      <= S_SNOOZE;
              r_snooze_cnt <= r_snooze_cnt + c_SCW'(1);
            end else begin
              r_state <= S_CLOCK;
            end
          end else if (tick_1hz) begin
            r_timer <= r_timer + c_TW'(1);
          end
        end
        S_SNOOZE: begin
          if (w_nav || center) begin
            r_state      <= S_CLOCK;
            r_snooze_cnt <= '0;
            r_timer      <= '0;
          end else if (w_snooze_expire) begin
            r_state <= S_RING;
            r_timer <= '0;
          end else if (tick_1hz) begin
            r_timer <= r_timer + c_TW'(1);
          end
        end
        default: begin
          r_state <= S_SET;
          r_field <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign adjust     = (r_state == S_SET);
  assign field_en   = adjust ? (c_FIELDS'(1) << r_field) : '0;
  assign ringing    = (r_state == S_RING);
  assign snoozing   = (r_state == S_SNOOZE);
  assign ring_id    = r_ring_id;
  assign snooze_cnt = r_snooze_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alarm_mode_ctrl.sv
`default_nettype none
// Randomised + directed bench for alarm_mode_ctrl; a per-cycle expectation queue
// fed by a behavioural mode model is drained by an independent monitor.
module tb_alarm_mode_ctrl;
  localparam int NA     = 2;
  localparam int SNZ    = 2;
  localparam int LIMIT  = 3;
  localparam int RINGS  = 3;
  localparam int IDLES  = 3;
  localparam int F      = 2 + 2 * NA;
  localparam int IDW    = 1;
  localparam int SCW    = 3;
`ifdef SET_TIMEOUT_EN
  localparam bit IDLE_ON = 1'b1;
`else
  localparam bit IDLE_ON = 1'b0;
`endif
  localparam logic [4:0] B_UP = 5'b10000, B_DN = 5'b01000, B_LF = 5'b00100,
                         B_RT = 5'b00010, B_CT = 5'b00001;
  localparam int M_SET = 0, M_CLOCK = 1, M_RING = 2, M_SNOOZE = 3;

  logic clk = 1'b0, rst = 1'b1, tick_1hz = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
  logic [5:0] secs = 6'd5;
  logic [NA-1:0] alarm_match = '0, alarm_armed = '0;
  logic adjust, ringing, snoozing;
  logic [F-1:0] field_en;
  logic [IDW-1:0] ring_id;
  logic [SCW-1:0] snooze_cnt;

  alarm_mode_ctrl #(
    .NUM_ALARMS(NA), .SNOOZE_SECS(SNZ), .SNOOZE_LIMIT(LIMIT),
    .RING_SECS(RINGS), .IDLE_SECS(IDLES)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .up(up), .down(down), .left(left), .right(right), .center(center),
    .secs(secs), .alarm_match(alarm_match), .alarm_armed(alarm_armed),
    .adjust(adjust), .field_en(field_en), .ringing(ringing), .ring_id(ring_id),
    .snoozing(snoozing), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           adj;
    logic [F-1:0]   fe;
    logic           rg;
    logic [IDW-1:0] id;
    logic           sz;
    logic [SCW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Model state: mode, selected field, alarm id, snoozes used, ticks seen in mode
  int m_mode = M_SET, m_field = 0, m_id = 0, m_cnt = 0, m_ticks = 0;
  bit m_fired = 1'b0;

  function automatic int lowest(input logic [NA-1:0] v);
    for (int k = 0; k < NA; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic model_step(input logic rs, input logic [4:0] b, input logic tk,
                            input logic [5:0] s, input logic [NA-1:0] m,
                            input logic [NA-1:0] a);
    bit nav, give_up, was_fired;
    int nxt;
    exp_t e;
    nav = b[4] | b[3] | b[2] | b[1];
    give_up = 1'b0;
    was_fired = m_fired;
    if (rs) begin
      m_mode = M_SET; m_field = 0; m_id = 0; m_cnt = 0; m_ticks = 0; m_fired = 1'b0;
    end else begin
      nxt = m_mode;
      if (s != 0) m_fired = 1'b0;
      case (m_mode)
        M_SET: begin
          if (b[1]) begin m_field = (m_field + 1) % F; m_ticks = 0; end
          else if (b[2]) begin m_field = (m_field + F - 1) % F; m_ticks = 0; end
          else if (b[0]) nxt = M_CLOCK;
          else if (b[4] | b[3]) m_ticks = 0;
          else if (tk && IDLE_ON) begin
            m_ticks++;
            if (m_ticks == IDLES) nxt = M_CLOCK;
          end
        end
        M_CLOCK: begin
          if (s == 0 && (m & a) != 0 && !was_fired) begin
            nxt = M_RING; m_id = lowest(m & a); m_cnt = 0; m_fired = 1'b1;
          end else if (b[0]) begin
            nxt = M_SET; m_field = 0;
          end
        end
        M_RING: begin
          if (nav) nxt = M_CLOCK;
          else begin
            if (b[0]) give_up = 1'b1;
            else if (tk) begin
              m_ticks++;
              if (m_ticks == RINGS) give_up = 1'b1;
            end
            if (give_up) begin
              if (m_cnt < LIMIT) begin m_cnt++; nxt = M_SNOOZE; end
              else nxt = M_CLOCK;
            end
          end
        end
        default: begin
          if (nav || b[0]) begin nxt = M_CLOCK; m_cnt = 0; end
          else if (tk) begin
            m_ticks++;
            if (m_ticks == SNZ) nxt = M_RING;
          end
        end
      endcase
      if (nxt != m_mode) m_ticks = 0;
      m_mode = nxt;
    end
    e.adj = (m_mode == M_SET);
    e.fe  = e.adj ? F'(1 << m_field) : '0;
    e.rg  = (m_mode == M_RING);
    e.sz  = (m_mode == M_SNOOZE);
    e.id  = IDW'(m_id);
    e.cnt = SCW'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rs, input logic [4:0] b, input logic tk,
                       input logic [5:0] s, input logic [NA-1:0] m,
                       input logic [NA-1:0] a);
    @(posedge clk);
    #2;
    rst = rs; {up, down, left, right, center} = b; tick_1hz = tk;
    secs = s; alarm_match = m; alarm_armed = a;
    model_step(rs, b, tk, s, m, a);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared #1 after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("adjust", 32'(adjust), 32'(e.adj));
        chk("field_en", 32'(field_en), 32'(e.fe));
        chk("ringing", 32'(ringing), 32'(e.rg));
        chk("ring_id", 32'(ring_id), 32'(e.id));
        chk("snoozing", 32'(snoozing), 32'(e.sz));
        chk("snooze_cnt", 32'(snooze_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    logic [4:0] b;
    int r;
    drive(1, 0, 0, 6'd5, 0, 0);
    drive(1, 0, 1, 6'd5, 0, 0);
    // field walk and wrap both ways
    for (int i = 0; i < F; i++) drive(0, B_RT, 0, 6'd5, 0, 0);
    drive(0, B_LF, 0, 6'd5, 0, 0);
    drive(0, B_CT, 0, 6'd5, 0, 0);
    drive(0, 0, 1, 6'd5, 2'b11, 2'b10);
    drive(0, 0, 0, 6'd0, 2'b11, 2'b10);
    // three manual snoozes then dismissal by the limit
    for (int k = 0; k < LIMIT; k++) begin
      drive(0, B_CT, 0, 6'd7, 2'b11, 2'b10);
      for (int t = 0; t < SNZ; t++) drive(0, 0, 1, 6'd7, 2'b11, 2'b10);
    end
    drive(0, B_CT, 0, 6'd7, 2'b11, 2'b10);
    drive(0, 0, 0, 6'd7, 2'b11, 2'b10);
    // ring timeout auto-snooze, then up dismisses
    drive(0, 0, 0, 6'd0, 2'b01, 2'b01);
    for (int t = 0; t < RINGS; t++) drive(0, 0, 1, 6'd9, 2'b01, 2'b01);
    drive(0, B_UP, 0, 6'd9, 2'b01, 2'b01);
    // snooze expiry coincident with left
    drive(0, 0, 0, 6'd0, 2'b01, 2'b11);
    drive(0, B_CT, 0, 6'd9, 2'b01, 2'b11);
    drive(0, 0, 1, 6'd9, 2'b01, 2'b11);
    drive(0, B_LF, 1, 6'd9, 2'b01, 2'b11);
    drive(0, 0, 0, 6'd9, 2'b01, 2'b11);
    // re-fire suppression while secs stays 0
    drive(0, 0, 0, 6'd0, 2'b11, 2'b11);
    drive(0, B_DN, 0, 6'd0, 2'b11, 2'b11);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 6'd0, 2'b11, 2'b11);
    drive(0, 0, 0, 6'd1, 2'b11, 2'b11);
    drive(0, 0, 0, 6'd0, 2'b11, 2'b11);
    // reset mid-ring, then idle ticks in SET
    drive(1, 0, 0, 6'd1, 2'b11, 2'b11);
    drive(0, 0, 0, 6'd1, 2'b11, 2'b11);
    for (int i = 0; i < IDLES + 1; i++) drive(0, 0, 1, 6'd1, 0, 0);
    drive(0, B_CT, 0, 6'd1, 0, 0);
    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 15);
      if (r < 5) b = 5'b00001 << r;
      else if (r == 5) b = 5'($urandom_range(1, 31));
      else b = 5'b0;
      drive(($urandom_range(0, 399) == 0), b, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 59)),
            NA'($urandom_range(0, 3)), NA'($urandom_range(0, 3)));
    end
    drive(0, 0, 0, 6'd5, 0, 0);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
